// File: rtl/fetch_cycle_hs.sv
// fetch_cycle_hs: instruction-fetch stage owning the PC, the instruction
// memory request/grant/response handshake (one request outstanding) and the
// IF/ID pipeline register read directly by decode.
//
// Optional feature: define FETCH_STATS_EN to add the fetch_cnt / kill_cnt
// statistics counters and their output ports. Without the macro the block is
// complete and behaves identically apart from those ports.

module fetch_cycle_hs #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] kill_cnt
`endif
);

    // Fetch controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pcF_q, pcF_d;
    logic [31:0] reqPc_q, reqPc_d;
    logic        kill_q, kill_d;
    logic [31:0] holdInstr_q, holdInstr_d;
    logic [31:0] holdPc_q, holdPc_d;

    logic [31:0] instrD_q;
    logic [31:0] pcD_q;
    logic [31:0] pcPlus4D_q;
    logic        validD_q;

    logic        deliver;
    logic [31:0] deliverInstr;
    logic [31:0] deliverPc;
    logic        discardRsp;
    logic        dropHold;

    // The request is presented only in REQ; the address always tracks PCF so
    // a redirect while the request is pending simply retargets it.
    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = pcF_q;

    // Next-state logic: FSM, PC update, kill tracking and hold buffer capture.
    always_comb begin
        state_d      = state_q;
        pcF_d        = pcF_q;
        reqPc_d      = reqPc_q;
        kill_d       = kill_q;
        holdInstr_d  = holdInstr_q;
        holdPc_d     = holdPc_q;
        deliver      = 1'b0;
        deliverInstr = holdInstr_q;
        deliverPc    = holdPc_q;
        discardRsp   = 1'b0;
        dropHold     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end

            ST_REQ: begin
                if (imem_gnt) begin
                    reqPc_d = pcF_q;
                    pcF_d   = pcF_q + 32'd4;
                    state_d = ST_WAIT;
                end
                if (PCSrcE) begin
                    pcF_d = PCTargetE;
                    if (imem_gnt) begin
                        kill_d = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || PCSrcE) begin
                        discardRsp = 1'b1;
                        kill_d     = 1'b0;
                        state_d    = ST_REQ;
                    end else if (!StallD) begin
                        deliver      = 1'b1;
                        deliverInstr = imem_rdata;
                        deliverPc    = reqPc_q;
                        state_d      = ST_REQ;
                    end else begin
                        holdInstr_d = imem_rdata;
                        holdPc_d    = reqPc_q;
                        state_d     = ST_HOLD;
                    end
                end else if (PCSrcE) begin
                    kill_d = 1'b1;
                end
                if (PCSrcE) begin
                    pcF_d = PCTargetE;
                end
            end

            ST_HOLD: begin
                if (PCSrcE) begin
                    dropHold = 1'b1;
                    pcF_d    = PCTargetE;
                    state_d  = ST_REQ;
                end else if (!StallD) begin
                    deliver = 1'b1;
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Fetch-side state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pcF_q       <= RESET_PC;
            reqPc_q     <= RESET_PC;
            kill_q      <= 1'b0;
            holdInstr_q <= NOP_INSTR;
            holdPc_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            pcF_q       <= pcF_d;
            reqPc_q     <= reqPc_d;
            kill_q      <= kill_d;
            holdInstr_q <= holdInstr_d;
            holdPc_q    <= holdPc_d;
        end
    end

    // IF/ID register: flush beats stall, stall beats a delivery, otherwise a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            instrD_q   <= NOP_INSTR;
            pcD_q      <= 32'd0;
            pcPlus4D_q <= 32'd0;
            validD_q   <= 1'b0;
        end else if (FlushD) begin
            instrD_q   <= NOP_INSTR;
            pcD_q      <= 32'd0;
            pcPlus4D_q <= 32'd0;
            validD_q   <= 1'b0;
        end else if (StallD) begin
            instrD_q   <= instrD_q;
            pcD_q      <= pcD_q;
            pcPlus4D_q <= pcPlus4D_q;
            validD_q   <= validD_q;
        end else if (deliver) begin
            instrD_q   <= deliverInstr;
            pcD_q      <= deliverPc;
            pcPlus4D_q <= deliverPc + 32'd4;
            validD_q   <= 1'b1;
        end else begin
            instrD_q   <= NOP_INSTR;
            validD_q   <= 1'b0;
        end
    end

    assign InstrD   = instrD_q;
    assign PCD      = pcD_q;
    assign PCPlus4D = pcPlus4D_q;
    assign ValidD   = validD_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fetchCnt_q;
    logic [31:0] killCnt_q;

    // Statistics: delivered instructions and thrown-away responses/buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchCnt_q <= 32'd0;
            killCnt_q  <= 32'd0;
        end else begin
            if (deliver && !FlushD) begin
                fetchCnt_q <= fetchCnt_q + 32'd1;
            end
            if (discardRsp || dropHold) begin
                killCnt_q <= killCnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetchCnt_q;
    assign kill_cnt  = killCnt_q;
`endif

endmodule

// File: tb/tb_fetch_cycle_hs.sv
// tb_fetch_cycle_hs: directed bench for fetch_cycle_hs. A behavioural memory
// answers grants after a programmable latency; expected IF/ID contents are
// queued when a fetch is set up and a monitor pops them on each new delivery.
`timescale 1ns/1ps

module tb_fetch_cycle_hs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'd0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] kill_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
    } ifidT;

    ifidT expQ[$];
    int   deliveryCycles[$];
    int   cycleCount = 0;

    logic [31:0] memData [logic [31:0]];
    int          grantsLeft = 0;
    int          latency = 1;
    int          pendCnt = 0;
    logic [31:0] pendAddr = 32'd0;

    fetch_cycle_hs dut (
        .clk         (clk),
        .rst         (rst),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .kill_cnt    (kill_cnt)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memData.exists(a)) return memData[a];
        return 32'hBAD0_0000 ^ a;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic flush, input logic redirect, input logic [31:0] target);
        @(negedge clk);
        StallD    = stall;
        FlushD    = flush;
        PCSrcE    = redirect;
        PCTargetE = target;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: %0d entries still pending, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Behavioural instruction memory: grants while grantsLeft > 0, answers after 'latency' cycles
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (rst) begin
                pendCnt = 0;
            end else begin
                if (pendCnt > 0) begin
                    pendCnt--;
                    if (pendCnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = memRead(pendAddr);
                    end
                end
                if (imem_req && grantsLeft > 0) begin
                    imem_gnt = 1'b1;
                    grantsLeft--;
                    pendAddr = imem_addr;
                    pendCnt  = latency;
                end
            end
        end
    end

    // Monitor: each new IF/ID delivery (valid, not a held stall cycle) is popped and compared
    initial begin
        logic stallAtEdge;
        logic rstAtEdge;
        ifidT e;
        forever begin
            @(posedge clk);
            stallAtEdge = StallD;
            rstAtEdge   = rst;
            #1;
            cycleCount++;
            if (!rstAtEdge && !stallAtEdge && ValidD === 1'b1) begin
                vectors++;
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_delivery: got InstrD=0x%08h PCD=0x%08h, expected no delivery", InstrD, PCD);
                end else begin
                    e = expQ.pop_front();
                    deliveryCycles.push_back(cycleCount);
                    if (InstrD !== e.instr || PCD !== e.pc || PCPlus4D !== e.pcPlus4) begin
                        miscompares++;
                        $display("[TB] FAIL delivery: got (0x%08h,0x%08h,0x%08h), expected (0x%08h,0x%08h,0x%08h)",
                                 InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pcPlus4);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus
    initial begin
        bit found;
        int gap;

        memData[32'h0000_0000] = 32'h0050_0093;
        memData[32'h0000_0004] = 32'h00A0_0113;
        memData[32'h0000_0008] = 32'h0040_0213;
        memData[32'h0000_0100] = 32'h0030_0193;
        memData[32'h0000_0104] = 32'h0020_8233;

        // Reset held for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_validd", {31'd0, ValidD}, 32'd0);
        checkOutput("reset_instrd", InstrD, 32'h0000_0013);
        checkOutput("reset_req", {31'd0, imem_req}, 32'd0);
        checkOutput("reset_addr", imem_addr, 32'h0000_0000);
`ifdef FETCH_STATS_EN
        checkOutput("reset_fetch_cnt", fetch_cnt, 32'd0);
        checkOutput("reset_kill_cnt", kill_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("idle_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("first_req", {31'd0, imem_req}, 32'd1);
        checkOutput("first_addr", imem_addr, 32'h0000_0000);

        // Zero-wait stream of two instructions
        expQ.push_back('{instr: 32'h0050_0093, pc: 32'h0, pcPlus4: 32'h4});
        expQ.push_back('{instr: 32'h00A0_0113, pc: 32'h4, pcPlus4: 32'h8});
        @(negedge clk);
        latency    = 1;
        grantsLeft = 2;
        waitDrain(20);
        gap = (deliveryCycles.size() >= 2) ? (deliveryCycles[1] - deliveryCycles[0]) : -1;
        checkOutput("stream_gap", gap, 32'd2);
        checkOutput("stream_next_addr", imem_addr, 32'h0000_0008);

        // Redirect while the slow response for 0x8 is outstanding
        latency    = 3;
        grantsLeft = 1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            if (imem_gnt) found = 1'b1;
        end
        checkOutput("redirect_gnt_seen", {31'd0, found}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0000);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #1;
            checkOutput("killed_validd", {31'd0, ValidD}, 32'd0);
            if (imem_req) found = 1'b1;
        end
        checkOutput("redirect_req", {31'd0, found}, 32'd1);
        checkOutput("redirect_addr", imem_addr, 32'h0000_0100);
        expQ.push_back('{instr: 32'h0030_0193, pc: 32'h100, pcPlus4: 32'h104});
        latency    = 1;
        grantsLeft = 1;
        waitDrain(20);
`ifdef FETCH_STATS_EN
        checkOutput("stats_fetch_cnt", fetch_cnt, 32'd3);
        checkOutput("stats_kill_cnt", kill_cnt, 32'd1);
`endif

        // Stall asserted when the response returns: captured into the hold buffer
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0000);
        latency    = 2;
        grantsLeft = 1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            if (imem_rvalid) found = 1'b1;
        end
        checkOutput("stall_rvalid_seen", {31'd0, found}, 32'd1);
        #1;
        checkOutput("hold_req", {31'd0, imem_req}, 32'd0);
        checkOutput("hold_instrd", InstrD, 32'h0000_0013);
        checkOutput("hold_validd", {31'd0, ValidD}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("hold_req_2", {31'd0, imem_req}, 32'd0);
        checkOutput("hold_instrd_2", InstrD, 32'h0000_0013);
        expQ.push_back('{instr: 32'h0020_8233, pc: 32'h104, pcPlus4: 32'h108});
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0000);
        @(posedge clk);
        #1;
        checkOutput("release_instrd", InstrD, 32'h0020_8233);
        checkOutput("release_validd", {31'd0, ValidD}, 32'd1);

        // Flush together with stall wins
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0000);
        @(posedge clk);
        #1;
        checkOutput("flush_instrd", InstrD, 32'h0000_0013);
        checkOutput("flush_validd", {31'd0, ValidD}, 32'd0);
        checkOutput("flush_pcd", PCD, 32'h0000_0000);
        checkOutput("flush_pcplus4d", PCPlus4D, 32'h0000_0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0000);
        repeat (3) @(negedge clk);

        checkOutput("queue_drained", expQ.size(), 32'd0);
`ifdef FETCH_STATS_EN
        checkOutput("final_fetch_cnt", fetch_cnt, 32'd4);
        checkOutput("final_kill_cnt", kill_cnt, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
